// File: rtl/systolic_pkg.sv
// Shared defaults and feeder state encoding for the systolic array edge feeder.
package systolic_pkg;

  localparam int unsigned N_DEF  = 2;
  localparam int unsigned DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/feeder_mat_buf.sv
// NxN operand matrix store with a single element write port.
// mem_c presents the contents as they will be after this cycle's write.
module feeder_mat_buf
  import systolic_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we_i,
  input  logic [$clog2(N)-1:0]   row_i,
  input  logic [$clog2(N)-1:0]   col_i,
  input  logic [DW-1:0]          data_i,
  output logic [N*N*DW-1:0]      mem_c
);

  logic [N*N*DW-1:0] mem_q;
  logic [N*N*DW-1:0] mem_d;

  // Indices that match no element (N not a power of two) are dropped here.
  always_comb begin
    mem_d = mem_q;
    for (int r = 0; r < int'(N); r++) begin
      for (int c = 0; c < int'(N); c++) begin
        if (we_i && (int'(row_i) == r) && (int'(col_i) == c)) begin
          mem_d[(r*N+c)*DW +: DW] = data_i;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign mem_c = mem_d;

endmodule

// File: rtl/systolic_feeder.sv
// Feeds skewed rows of A and columns of B into the edges of an NxN systolic array.
// Define SYSTOLIC_FEEDER_PERF_EN to add the 16-bit run_count output.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic                  load_sel,
  input  logic [$clog2(N)-1:0]  load_row,
  input  logic [$clog2(N)-1:0]  load_col,
  input  logic [DW-1:0]         load_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [N*DW-1:0]       a_edge,
  output logic [N*DW-1:0]       b_edge
`ifdef SYSTOLIC_FEEDER_PERF_EN
  ,
  output logic [15:0]           run_count
`endif
);

  localparam int unsigned TW = $clog2(2*N);

  feeder_state_e   state_q, state_d;
  logic [TW-1:0]   t_q, t_d;
  logic [N*DW-1:0] a_edge_d, b_edge_d;
  logic [N*N*DW-1:0] a_nxt, b_nxt;
  logic            we_a, we_b;

  assign we_a = load_valid & load_ready & ~load_sel;
  assign we_b = load_valid & load_ready &  load_sel;

  feeder_mat_buf #(.N(N), .DW(DW)) u_mat_a (
    .clk    (clk),
    .rst    (rst),
    .we_i   (we_a),
    .row_i  (load_row),
    .col_i  (load_col),
    .data_i (load_data),
    .mem_c  (a_nxt)
  );

  feeder_mat_buf #(.N(N), .DW(DW)) u_mat_b (
    .clk    (clk),
    .rst    (rst),
    .we_i   (we_b),
    .row_i  (load_row),
    .col_i  (load_col),
    .data_i (load_data),
    .mem_c  (b_nxt)
  );

  // Run sequencing: FEED 2N-1 cycles, FLUSH N cycles, DONE one cycle.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      IDLE, DONE: begin
        t_d     = '0;
        state_d = start ? FEED : IDLE;
      end
      FEED: begin
        if (t_q == TW'(2*N-2)) begin
          state_d = FLUSH;
          t_d     = '0;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      FLUSH: begin
        if (t_q == TW'(N-1)) begin
          state_d = DONE;
          t_d     = '0;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        t_d     = '0;
      end
    endcase
  end

  // Skew mux looks at the next state and post-write contents so the edge
  // registers line up with t and a write alongside start is seen at t=0.
  always_comb begin
    a_edge_d = '0;
    b_edge_d = '0;
    if (state_d == FEED) begin
      for (int i = 0; i < int'(N); i++) begin
        for (int k = 0; k < int'(N); k++) begin
          if (int'(t_d) == i + k) begin
            a_edge_d[i*DW +: DW] = a_nxt[(i*N+k)*DW +: DW];
            b_edge_d[i*DW +: DW] = b_nxt[(k*N+i)*DW +: DW];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      t_q        <= '0;
      a_edge     <= '0;
      b_edge     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      a_edge     <= a_edge_d;
      b_edge     <= b_edge_d;
      busy       <= (state_d == FEED) || (state_d == FLUSH);
      done       <= (state_d == DONE);
      load_ready <= (state_d == IDLE) || (state_d == DONE);
    end
  end

`ifdef SYSTOLIC_FEEDER_PERF_EN
  logic [15:0] run_count_q;

  // Counts alongside the done pulse; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_count_q <= '0;
    end else if (state_d == DONE) begin
      run_count_q <= run_count_q + 16'd1;
    end
  end

  assign run_count = run_count_q;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized self-checking bench for systolic_feeder with a matrix-level model
// and a behavioural 2D PE array consuming the edge outputs.
module tb_systolic_feeder;

  localparam int unsigned N  = 2;
  localparam int unsigned DW = 8;
  localparam int unsigned IW = $clog2(N);

  logic              clk = 1'b0;
  logic              rst;
  logic              load_valid;
  logic              load_ready;
  logic              load_sel;
  logic [IW-1:0]     load_row;
  logic [IW-1:0]     load_col;
  logic [DW-1:0]     load_data;
  logic              start;
  logic              busy;
  logic              done;
  logic [N*DW-1:0]   a_edge;
  logic [N*DW-1:0]   b_edge;
`ifdef SYSTOLIC_FEEDER_PERF_EN
  logic [15:0]       run_count;
  int                exp_runs = 0;
`endif

  always #5 clk = ~clk;

  systolic_feeder #(.N(N), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_sel   (load_sel),
    .load_row   (load_row),
    .load_col   (load_col),
    .load_data  (load_data),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .a_edge     (a_edge),
    .b_edge     (b_edge)
`ifdef SYSTOLIC_FEEDER_PERF_EN
    ,
    .run_count  (run_count)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int a_m [N][N];
  int b_m [N][N];

  // Downstream PE array: a flows right, b flows down, acc += a*b each cycle.
  int acc [N][N];
  int ar  [N][N];
  int br  [N][N];

  function automatic int pe_a_in(int i, int j);
    if (j == 0) return int'($signed(a_edge[i*DW +: DW]));
    return ar[i][j-1];
  endfunction

  function automatic int pe_b_in(int i, int j);
    if (i == 0) return int'($signed(b_edge[j*DW +: DW]));
    return br[i-1][j];
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < int'(N); i++) begin
      for (int j = 0; j < int'(N); j++) begin
        if (rst || done) begin
          acc[i][j] <= 0;
          ar[i][j]  <= 0;
          br[i][j]  <= 0;
        end else begin
          acc[i][j] <= acc[i][j] + pe_a_in(i, j) * pe_b_in(i, j);
          ar[i][j]  <= pe_a_in(i, j);
          br[i][j]  <= pe_b_in(i, j);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*DW-1:0] exp_edge(input bit is_b, input int t);
    logic [N*DW-1:0] v;
    v = '0;
    for (int s = 0; s < int'(N); s++) begin
      if (t - s >= 0 && t - s < int'(N)) begin
        v[s*DW +: DW] = is_b ? DW'(b_m[t-s][s]) : DW'(a_m[s][t-s]);
      end
    end
    return v;
  endfunction

  function automatic int matmul(input int i, input int j);
    int s;
    s = 0;
    for (int k = 0; k < int'(N); k++) s += a_m[i][k] * b_m[k][j];
    return s;
  endfunction

  task automatic model_write(input bit sel, input int r, input int c, input int d);
    if (sel) b_m[r][c] = d;
    else     a_m[r][c] = d;
  endtask

  task automatic drive_load(input bit v, input bit sel, input int r, input int c, input int d);
    load_valid = v;
    load_sel   = sel;
    load_row   = IW'(r);
    load_col   = IW'(c);
    load_data  = DW'(d);
  endtask

  task automatic write_elem(input bit sel, input int r, input int c, input int d);
    drive_load(1'b1, sel, r, c, d);
    step();
    load_valid = 1'b0;
    model_write(sel, r, c, d);
  endtask

  task automatic kick(input bit wr, input bit sel, input int r, input int c, input int d);
    start = 1'b1;
    drive_load(wr, sel, r, c, d);
    step();
    start      = 1'b0;
    load_valid = 1'b0;
    if (wr) model_write(sel, r, c, d);
  endtask

  // Entered at FEED t=0; checks every cycle of the run through DONE.
  task automatic run_body(input string tag, input bit hold, input bit lock);
    bit exp_busy, exp_done;
    logic [N*DW-1:0] ea, eb;
    for (int k = 0; k < 3*int'(N); k++) begin
      exp_busy = (k < 3*int'(N) - 1);
      exp_done = (k == 3*int'(N) - 1);
      ea = (k < 2*int'(N) - 1) ? exp_edge(1'b0, k) : '0;
      eb = (k < 2*int'(N) - 1) ? exp_edge(1'b1, k) : '0;
      check($sformatf("%s a_edge k%0d", tag, k), 64'(a_edge), 64'(ea));
      check($sformatf("%s b_edge k%0d", tag, k), 64'(b_edge), 64'(eb));
      check($sformatf("%s busy k%0d", tag, k), 64'(busy), 64'(exp_busy));
      check($sformatf("%s done k%0d", tag, k), 64'(done), 64'(exp_done));
      check($sformatf("%s ready k%0d", tag, k), 64'(load_ready), 64'(!exp_busy));
      if (exp_done) begin
        for (int i = 0; i < int'(N); i++)
          for (int j = 0; j < int'(N); j++)
            check($sformatf("%s C[%0d][%0d]", tag, i, j), 64'(acc[i][j]), 64'(matmul(i, j)));
`ifdef SYSTOLIC_FEEDER_PERF_EN
        exp_runs++;
        check($sformatf("%s run_count", tag), 64'(run_count), 64'(16'(exp_runs)));
`endif
      end
      start = hold || (lock && k == 1);
      drive_load(lock && k == 1, 1'b0, 0, 0, a_m[0][0] + 1);
      step();
    end
    start      = 1'b0;
    load_valid = 1'b0;
    if (!hold) begin
      check({tag, " idle busy"}, 64'(busy), 64'(0));
      check({tag, " idle done"}, 64'(done), 64'(0));
      check({tag, " idle ready"}, 64'(load_ready), 64'(1));
      check({tag, " idle a_edge"}, 64'(a_edge), 64'(0));
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    drive_load(1'b0, 1'b0, 0, 0, 0);
    for (int i = 0; i < int'(N); i++)
      for (int j = 0; j < int'(N); j++) begin
        a_m[i][j] = 0;
        b_m[i][j] = 0;
      end
    #3;
    check("rst a_edge", 64'(a_edge), 64'(0));
    check("rst b_edge", 64'(b_edge), 64'(0));
    check("rst busy", 64'(busy), 64'(0));
    check("rst done", 64'(done), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    step();
    check("post-rst ready", 64'(load_ready), 64'(1));

    // Directed skew / end-to-end data
    write_elem(0, 0, 0, 1); write_elem(0, 0, 1, 2);
    write_elem(0, 1, 0, 3); write_elem(0, 1, 1, 4);
    write_elem(1, 0, 0, 5); write_elem(1, 0, 1, 6);
    write_elem(1, 1, 0, 7); write_elem(1, 1, 1, 8);
    kick(0, 0, 0, 0, 0);
    check("skew t0 a_edge", 64'(a_edge), 64'(16'h0001));
    check("skew t0 b_edge", 64'(b_edge), 64'(16'h0005));
    run_body("dir", 0, 0);
    check("dir C00 const", 64'(matmul(0, 0)), 64'(19));

    // Lockout: load and start during FEED are ignored
    kick(0, 0, 0, 0, 0);
    run_body("lock", 0, 1);
    kick(0, 0, 0, 0, 0);
    run_body("after-lock", 0, 0);

    // Same-cycle write with start
    kick(1, 0, 0, 0, -128);
    check("samecyc a slice0", 64'(a_edge[DW-1:0]), 64'(8'h80));
    run_body("samecyc", 0, 0);

    // Randomized loads and runs
    for (int it = 0; it < 8; it++) begin
      int nw;
      nw = int'($urandom_range(2, 8));
      for (int w = 0; w < nw; w++) begin
        bit v, sel;
        int r, c, d;
        v   = 1'($urandom_range(0, 3) != 0);
        sel = 1'($urandom_range(0, 1));
        r   = int'($urandom_range(0, N-1));
        c   = int'($urandom_range(0, N-1));
        d   = int'($urandom_range(0, 255)) - 128;
        drive_load(v, sel, r, c, d);
        step();
        load_valid = 1'b0;
        if (v) model_write(sel, r, c, d);
      end
      kick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, N-1)), int'($urandom_range(0, N-1)),
           int'($urandom_range(0, 255)) - 128);
      run_body($sformatf("rnd%0d", it), 0, 1'($urandom_range(0, 1)));
    end

    // Three back-to-back runs with start held high
    start = 1'b1;
    step();
    run_body("b2b0", 1, 0);
    run_body("b2b1", 1, 0);
    run_body("b2b2", 0, 0);

    // Reset in the middle of FEED
    kick(0, 0, 0, 0, 0);
    step();
    #2;
    rst = 1'b1;
    #1;
    check("midrst a_edge", 64'(a_edge), 64'(0));
    check("midrst b_edge", 64'(b_edge), 64'(0));
    check("midrst busy", 64'(busy), 64'(0));
    check("midrst done", 64'(done), 64'(0));
    step();
    rst = 1'b0;
`ifdef SYSTOLIC_FEEDER_PERF_EN
    exp_runs = 0;
`endif
    for (int i = 0; i < int'(N); i++)
      for (int j = 0; j < int'(N); j++) begin
        a_m[i][j] = 0;
        b_m[i][j] = 0;
      end
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("midrst no-done %0d", k), 64'(done), 64'(0));
      check($sformatf("midrst no-busy %0d", k), 64'(busy), 64'(0));
    end
    kick(0, 0, 0, 0, 0);
    run_body("zeroed", 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 The block SHALL have parameter N, default 2, meaning the array dimension (the array is NxN; N is at least 2).
REQ-002 The block SHALL have parameter DW, default 8, meaning the signed width of each operand element.
REQ-003 Port clk, input, 1 bit: clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port load_valid, input, 1 bit: write request for one matrix element.
REQ-006 Port load_ready, output, 1 bit: the block accepts element writes.
REQ-007 Port load_sel, input, 1 bit: selects the target matrix (0 = A, 1 = B).
REQ-008 Port load_row and port load_col, input, clog2(N) bits each: element index.
REQ-009 Port load_data, input, DW bits, signed: element value.
REQ-010 Port start, input, 1 bit: request one feed run.
REQ-011 Port busy, output, 1 bit: a run is in progress.
REQ-012 Port done, output, 1 bit: one-cycle pulse at the end of a run.
REQ-013 Port a_edge, output, N*DW bits: slice i drives a_in of array PE(i,0).
REQ-014 Port b_edge, output, N*DW bits: slice j drives b_in of array PE(0,j).

Function
REQ-015 The block SHALL hold two NxN signed DW-bit matrices, A and B.
REQ-016 An element write SHALL occur when load_valid and load_ready are both high in the same cycle; the write stores load_data at [load_row][load_col] of the matrix selected by load_sel.
REQ-017 The state machine SHALL have exactly these states: IDLE, FEED, FLUSH, DONE.
REQ-018 load_ready SHALL be high in IDLE and DONE, and low in FEED and FLUSH; out-of-range indices SHALL be ignored.
REQ-019 In IDLE or DONE, start SHALL move the state to FEED with t=0 on the next cycle; a write accepted in the same cycle as start SHALL be visible to that run.
REQ-020 start SHALL be ignored while in FEED or FLUSH.
REQ-021 FEED SHALL last 2N-1 cycles, t=0..2N-2; slice i of a_edge = A[i][t-i] when 0<=t-i<N, otherwise 0.
REQ-022 During FEED, slice j of b_edge = B[t-j][j] when 0<=t-j<N, otherwise 0.
REQ-023 The edge outputs SHALL be registered and SHALL change only on clock edges.
REQ-024 FLUSH SHALL last N cycles, with a_edge and b_edge at 0, so that the last product reaches PE(N-1,N-1).
REQ-025 DONE SHALL last one cycle, with done=1, then return to IDLE, unless start is high, in which case the state moves to FEED.
REQ-026 busy SHALL be 1 in FEED and FLUSH, and 0 otherwise.
REQ-027 In IDLE and DONE, both edge outputs SHALL be 0.
REQ-028 The stored matrices SHALL persist across runs until overwritten.
REQ-029 The block SHALL NOT perform arithmetic; the elements pass through bit-exact.

Reset
REQ-030 rst SHALL force, asynchronously: state IDLE, t=0, a_edge=0, b_edge=0, busy=0, done=0, and all matrix elements 0.
REQ-031 rst asserted mid-run SHALL abort the run without asserting done.
REQ-032 After rst deasserts, load_ready SHALL be 1 on the first clock edge.

Configuration
REQ-033 With SYSTOLIC_FEEDER_PERF_EN defined, the block SHALL add output run_count, 16 bits, which increments by one on each done pulse, wraps 0xFFFF->0, and resets to 0.
REQ-034 Without SYSTOLIC_FEEDER_PERF_EN, the run_count port and its counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-035 The shared package systolic_pkg SHALL define the defaults for N and DW and the feeder state enum (IDLE, FEED, FLUSH, DONE).
REQ-036 Matrix storage and the write port SHALL be one sub-module, feeder_mat_buf, instantiated once for A and once for B; the skew muxing SHALL stay in the top level.

Verification
REQ-037 Scenario 1 (skew): N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], start -> a_edge rows over t0..t2 = (1,0),(2,3),(0,4); b_edge cols = (5,0),(7,6),(0,8).
REQ-038 Scenario 2 (end to end): same data driving a 2x2 PE array -> C=[[19,22],[43,50]] when done pulses, 6 cycles after the start edge.
REQ-039 Scenario 3 (busy lockout): a load attempt and a start during FEED -> load_ready=0, the matrix is unchanged, and no second run occurs.
REQ-040 Scenario 4 (same-cycle write): in IDLE, write A[0][0]=-128 in the same cycle as start -> a_edge slice 0 = -128 (0x80) at t=0.
REQ-041 Scenario 5 (reset mid-run): rst at FEED t=1 -> all outputs 0, no done pulse, a later run sees zeroed matrices.
REQ-042 Scenario 6 (perf counter): SYSTOLIC_FEEDER_PERF_EN defined, 3 back-to-back runs with start held high -> run_count=3, with each run taking 2N-1+N+1 cycles.
